// File: rtl/fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_reader
// Description : Drains an upstream show-ahead FIFO into a 2-entry in-order
//               skid buffer with a valid/ready downstream port. The upstream
//               pop never depends combinationally on down_ready.
//               Optional feature macro: FIFO_READER_WORD_COUNT_EN enables a
//               16-bit wrapping count of downstream transfers; without it
//               word_count is tied to zero and no counter register exists.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_reader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             empty,
    input  logic [WIDTH-1:0] read_data,
    output logic             pop,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [WIDTH-1:0] down_data,
    input  logic             flush,
    output logic [15:0]      word_count
);

    localparam logic [1:0] c_CNT_EMPTY = 2'd0;
    localparam logic [1:0] c_CNT_ONE   = 2'd1;
    localparam logic [1:0] c_CNT_FULL  = 2'd2;

    logic [1:0]       r_count;
    logic [WIDTH-1:0] r_head;   // oldest buffered word
    logic [WIDTH-1:0] r_tail;   // younger word, valid only when r_count == 2
    logic             w_pop;
    logic             w_xfer;

    // Pop only from registered occupancy and upstream/control inputs; rst
    // gates it so pop drops the instant reset is asserted.
    assign w_pop      = ~rst & ~empty & (r_count != c_CNT_FULL) & ~flush;
    assign w_xfer     = (r_count != c_CNT_EMPTY) & down_ready;

    assign pop        = w_pop;
    assign down_valid = (r_count != c_CNT_EMPTY);
    assign down_data  = r_head;

    // Occupancy: flush empties the buffer; simultaneous pop and transfer
    // leave it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= c_CNT_EMPTY;
        end else if (flush) begin
            r_count <= c_CNT_EMPTY;
        end else if (w_pop && !w_xfer) begin
            r_count <= r_count + 2'd1;
        end else if (!w_pop && w_xfer) begin
            r_count <= r_count - 2'd1;
        end
    end

    // Data path keeps the oldest word in r_head; contents are don't-care
    // while empty, so these registers carry no reset.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            if (w_pop) begin
                if (r_count == c_CNT_ONE) begin
                    r_head <= read_data;
                end else begin
                    r_head <= r_tail;
                    r_tail <= read_data;
                end
            end else begin
                r_head <= r_tail;
            end
        end else if (w_pop) begin
            if (r_count == c_CNT_EMPTY) begin
                r_head <= read_data;
            end else begin
                r_tail <= read_data;
            end
        end
    end

`ifdef FIFO_READER_WORD_COUNT_EN
    logic [15:0] r_word_count;

    // Count every downstream transfer, including one coincident with flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_count <= 16'd0;
        end else if (w_xfer) begin
            r_word_count <= r_word_count + 16'd1;
        end
    end

    assign word_count = r_word_count;
`else
    assign word_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 The block SHALL have parameter width, default 8, meaning data width in bits.
REQ-002 The block SHALL have these ports, one per line:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- empty  input  1  upstream FIFO empty flag
- read_data  input  width  upstream FIFO head word, valid whenever empty is low
- pop  output  1  removes the upstream head word at this rising edge
- down_valid  output  1  down_data holds a word
- down_ready  input  1  downstream accepts a word
- down_data  output  width  word offered downstream
- flush  input  1  synchronous discard of buffered words
- word_count  output  16  accepted-transfer counter (see REQ-018)
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high on port rst.

Function
REQ-004 The block SHALL hold a 2-entry in-order buffer with occupancy count 0..2 held in a register.
REQ-005 pop SHALL equal (~empty & count < 2 & ~flush), from registers and inputs only, with no combinational path from down_ready.
REQ-006 A downstream transfer SHALL occur on a rising edge where down_valid and down_ready are both high.
REQ-007 down_valid SHALL equal (count != 0), and down_data SHALL be the oldest buffered word.
REQ-008 A popped word SHALL be captured at the edge where pop is high, and SHALL be visible on down_data no earlier than the next cycle (1-cycle latency).
REQ-009 On a simultaneous pop and transfer, count SHALL be unchanged, and ordering SHALL be preserved.
REQ-010 Sustained ~empty with down_ready high SHALL yield one transfer per cycle after the first word.
REQ-011 With count == 2, pop SHALL be low even if down_ready is high, and down_valid/down_data SHALL be held stable until transfer.
REQ-012 While down_valid is high and down_ready is low, down_data SHALL NOT change.
REQ-013 When flush is high at an edge, count SHALL become 0, any transfer that cycle SHALL still be counted, and no pop SHALL occur.
REQ-014 The block SHALL NOT assert pop while empty is high, in any state.

Reset
REQ-015 Asserting rst SHALL immediately force count = 0, down_valid = 0, pop = 0 and word_count = 0, independent of clk.
REQ-016 Buffer data registers need not be reset; down_data is don't-care while down_valid = 0.
REQ-017 Reset mid-transfer SHALL discard buffered words, and the block SHALL resume popping on the first edge after rst deasserts.

Configuration
REQ-018 With macro FIFO_READER_WORD_COUNT_EN defined, word_count SHALL increment by 1 per transfer, wrapping 16'hFFFF -> 0; without it, word_count SHALL be constant 0 and no counter register SHALL exist.
REQ-019 All other behaviour SHALL be identical with or without FIFO_READER_WORD_COUNT_EN.

Verification
REQ-020 The bench SHALL drive the block from ff_fifo_with_reg_empty_full (width 8, depth 5), checking order against a queue model, and SHALL cover the following scenarios:
- Fill FIFO with 8'h00,8'h11,..,8'h44, down_ready = 1 -> down_data 00,11,22,33,44 on consecutive cycles; pop never high while empty.
- down_ready = 0 for 10 cycles after 3 pushes -> count saturates at 2, pop low, down_data = 8'h00 stable; release -> 00,11,22 in order.
- Back-to-back push, with down_ready toggling 1010 for 50 cycles -> zero loss and duplication, order preserved.
- flush while count == 2 and down_ready = 0 -> down_valid = 0 next cycle, FIFO contents untouched, next word delivered after flush drops.
- rst asserted mid-stream between clock edges -> pop/down_valid low before next edge; after release, resumes with the FIFO head.
- With FIFO_READER_WORD_COUNT_EN, preload the counter path by 65537 transfers -> word_count = 1; without the macro -> word_count = 0 throughout.
